// File: rtl/dii_packet_arbiter_pkg.sv
// rtl/dii_packet_arbiter_pkg.sv - DII flit type, FSM states and pointer helper for the packet arbiter
package dii_packet_arbiter_pkg;

    localparam int DII_FLIT_WIDTH = 18;

    // One debug-ring flit: handshake valid, end-of-packet marker, 16-bit payload.
    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // Advance a port index by one, wrapping back to port 0 after the highest port.
    function automatic int wrap_inc(input int p, input int ports);
        return (p + 1 >= ports) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/dii_packet_arbiter_if.sv
// rtl/dii_packet_arbiter_if.sv - requester/ring handshake bundle for the DII packet arbiter
interface dii_packet_arbiter_if #(
    parameter int PORTS      = 2,
    parameter int PORT_IDX_W = 3
) ();
    import dii_packet_arbiter_pkg::*;

    dii_flit [PORTS-1:0]   req_in;
    logic    [PORTS-1:0]   req_in_ready;
    dii_flit               ring_out;
    logic                  ring_out_ready;
    logic [PORT_IDX_W-1:0] grant_idx;
    logic                  locked;

    // Master side: the flit sources and the downstream ring hop.
    modport master (
        output req_in,
        input  req_in_ready,
        input  ring_out,
        output ring_out_ready,
        input  grant_idx,
        input  locked
    );

    // Slave side: the arbiter itself.
    modport slave (
        input  req_in,
        output req_in_ready,
        output ring_out,
        input  ring_out_ready,
        output grant_idx,
        output locked
    );

endinterface

// File: rtl/dii_packet_arbiter_rr.sv
// rtl/dii_packet_arbiter_rr.sv - combinational round-robin pick starting at a pointer
module dii_packet_arbiter_rr #(
    parameter int PORTS      = 2,
    parameter int PORT_IDX_W = 3
) (
    input  logic [PORTS-1:0]      req,
    input  logic [PORT_IDX_W-1:0] ptr,
    output logic [PORTS-1:0]      gnt,
    output logic [PORT_IDX_W-1:0] idx
);

    // Scan upward from ptr with wrap-around and keep the first requester seen.
    always_comb begin : pick
        int  j;
        logic found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < PORTS; k++) begin
            j = int'(ptr) + k;
            if (j >= PORTS) begin
                j = j - PORTS;
            end
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = PORT_IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/dii_packet_arbiter.sv
// rtl/dii_packet_arbiter.sv - per-packet round-robin arbiter of local DII flit sources onto one ring hop
module dii_packet_arbiter #(
    parameter int PORTS      = 2,
    parameter int PORT_IDX_W = 3
) (
    input logic                 clk,
    input logic                 rst,
    dii_packet_arbiter_if.slave dii
);
    import dii_packet_arbiter_pkg::*;

    arb_state_e            state_q, state_d;
    logic [PORT_IDX_W-1:0] owner_q, owner_d;
    logic [PORT_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [PORT_IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic                  locked_q, locked_d;
    dii_flit               out_q, out_d;

    logic [PORTS-1:0]      req_valid;
    logic [PORTS-1:0]      rr_gnt;
    logic [PORT_IDX_W-1:0] rr_idx;
    logic                  load_en;
    logic [PORT_IDX_W-1:0] sel;
    dii_flit               sel_flit;
    logic [PORTS-1:0]      ready;
    logic                  xfer;

    // Gather the per-port valid bits for the round-robin picker.
    always_comb begin
        req_valid = '0;
        for (int i = 0; i < PORTS; i++) begin
            req_valid[i] = dii.req_in[i].valid;
        end
    end

    dii_packet_arbiter_rr #(
        .PORTS      (PORTS),
        .PORT_IDX_W (PORT_IDX_W)
    ) u_rr (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .gnt (rr_gnt),
        .idx (rr_idx)
    );

    // Choose the serving port (owner while locked, rr pick while idle) and decode its ready.
    always_comb begin
        load_en  = !out_q.valid || dii.ring_out_ready;
        sel      = (state_q == ST_LOCKED) ? owner_q : rr_idx;
        sel_flit = '0;
        ready    = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (sel == PORT_IDX_W'(i)) begin
                sel_flit = dii.req_in[i];
            end
            if (state_q == ST_LOCKED) begin
                ready[i] = (owner_q == PORT_IDX_W'(i));
            end else begin
                ready[i] = rr_gnt[i];
            end
        end
        if (!rst || !load_en) begin
            ready = '0;
        end
        xfer = |(ready & req_valid);
    end

    // Next-state logic: output register load plus IDLE/LOCKED packet tracking.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        grant_idx_d = grant_idx_q;
        locked_d    = locked_q;
        out_d       = out_q;

        if (load_en) begin
            if (xfer) begin
                out_d = sel_flit;
            end else begin
                out_d = '0;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    grant_idx_d = sel;
                    if (sel_flit.last) begin
                        rr_ptr_d = PORT_IDX_W'(wrap_inc(int'(sel), PORTS));
                    end else begin
                        state_d  = ST_LOCKED;
                        owner_d  = sel;
                        locked_d = 1'b1;
                    end
                end
            end
            ST_LOCKED: begin
                // Release only; the next packet is picked from IDLE one cycle later.
                if (xfer) begin
                    grant_idx_d = sel;
                    if (sel_flit.last) begin
                        state_d  = ST_IDLE;
                        locked_d = 1'b0;
                        rr_ptr_d = PORT_IDX_W'(wrap_inc(int'(owner_q), PORTS));
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any partially sent packet.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            locked_q    <= 1'b0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
            locked_q    <= locked_d;
            out_q       <= out_d;
        end
    end

    assign dii.req_in_ready = ready;
    assign dii.ring_out     = out_q;
    assign dii.grant_idx    = grant_idx_q;
    assign dii.locked       = locked_q;

endmodule

// File: tb/tb_dii_packet_arbiter.sv
// tb/tb_dii_packet_arbiter.sv - randomized scoreboard bench for dii_packet_arbiter
module tb_dii_packet_arbiter;
    import dii_packet_arbiter_pkg::*;

    localparam int P  = 3;
    localparam int IW = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dii_packet_arbiter_if #(.PORTS(P), .PORT_IDX_W(IW)) dii ();

    dii_packet_arbiter #(.PORTS(P), .PORT_IDX_W(IW)) dut (
        .clk (clk),
        .rst (rst),
        .dii (dii)
    );

    int errors = 0;
    int checks = 0;

    // Expected flits in the order they must leave on ring_out.
    dii_flit sb[$];

    // Per-port packet generator: position in packet, packet length, packet number.
    int pos[P];
    int len[P];
    int seq[P];
    int prob[P];
    int rdy_prob;
    int len_lo;
    int len_hi;
    bit v[P];

    // Reference model: packet owner (-1 none), round-robin start, last grant, lock flag.
    int       m_owner;
    int       m_ptr;
    int       m_grant;
    bit       m_locked;
    bit       m_full;
    logic     rst_val;
    bit       d_load;
    int       d_xfer;
    logic [P-1:0] d_ready;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int new_len();
        return int'($urandom_range(len_hi, len_lo));
    endfunction

    function automatic dii_flit port_flit(input int p);
        dii_flit f;
        f.valid = 1'b1;
        f.last  = (pos[p] == len[p] - 1);
        f.data  = {4'(p), 8'(seq[p]), 4'(pos[p])};
        return f;
    endfunction

    task automatic set_len(input int lo, input int hi);
        len_lo = lo;
        len_hi = hi;
        for (int p = 0; p < P; p++) begin
            if (pos[p] == 0) len[p] = new_len();
        end
    endtask

    // One clock: retire last cycle's decision, check registered outputs, drive and predict ready.
    task automatic step(input logic rl);
        dii_flit f;
        int      cand;
        int      q;
        @(posedge clk);
        if (!rst_val) begin
            m_full   = 1'b0;
            m_owner  = -1;
            m_ptr    = 0;
            m_grant  = 0;
            m_locked = 1'b0;
            sb.delete();
            for (int p = 0; p < P; p++) begin
                if (pos[p] != 0) begin
                    pos[p] = 0;
                    seq[p]++;
                    len[p] = new_len();
                end
            end
        end else begin
            if (d_load) m_full = (d_xfer >= 0);
            if (d_xfer >= 0) begin
                f = port_flit(d_xfer);
                sb.push_back(f);
                m_grant = d_xfer;
                if (f.last) begin
                    m_owner  = -1;
                    m_locked = 1'b0;
                    m_ptr    = (d_xfer + 1) % P;
                    pos[d_xfer] = 0;
                    seq[d_xfer]++;
                    len[d_xfer] = new_len();
                end else begin
                    m_owner  = d_xfer;
                    m_locked = 1'b1;
                    pos[d_xfer]++;
                end
            end
        end
        #1;
        chk("locked", 32'(dii.locked), 32'(m_locked));
        chk("grant_idx", 32'(dii.grant_idx), 32'(m_grant));

        rst_val = rl;
        rst     = rl;
        dii.ring_out_ready = ($urandom % 100) < rdy_prob;
        for (int p = 0; p < P; p++) begin
            v[p] = ($urandom % 100) < prob[p];
            if (v[p]) dii.req_in[p] = port_flit(p);
            else      dii.req_in[p] = {1'b0, 17'($urandom)};
        end

        d_ready = '0;
        d_xfer  = -1;
        d_load  = !m_full || dii.ring_out_ready;
        if (rst_val && d_load) begin
            cand = -1;
            if (m_owner >= 0) begin
                cand = m_owner;
            end else begin
                for (int k = 0; k < P; k++) begin
                    q = (m_ptr + k) % P;
                    if (cand < 0 && v[q]) cand = q;
                end
            end
            if (cand >= 0) begin
                d_ready[cand] = 1'b1;
                if (v[cand]) d_xfer = cand;
            end
        end
        #1;
        chk("req_in_ready", 32'(dii.req_in_ready), 32'(d_ready));
    endtask

    task automatic run(input int n, input int p0, input int p1, input int p2, input int rp, input logic rl);
        prob[0]  = p0;
        prob[1]  = p1;
        prob[2]  = p2;
        rdy_prob = rp;
        repeat (n) step(rl);
    endtask

    // Monitor: whenever ring_out is sampled, it must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                chk("ring_out_flit", 32'(dii.ring_out), 32'(sb[0]));
                if (dii.ring_out_ready) void'(sb.pop_front());
            end else begin
                chk("ring_out_valid_idle", 32'(dii.ring_out.valid), 32'd0);
            end
        end
    end

    initial begin
        rst_val = 1'b0;
        rst     = 1'b0;
        d_load  = 1'b0;
        d_xfer  = -1;
        d_ready = '0;
        dii.ring_out_ready = 1'b1;
        for (int p = 0; p < P; p++) begin
            pos[p] = 0;
            seq[p] = 0;
            v[p]   = 1'b1;
        end
        set_len(4, 4);
        seq[0] = 1;
        for (int p = 0; p < P; p++) dii.req_in[p] = port_flit(p);

        // Reset held with every source valid.
        run(3, 100, 100, 100, 100, 1'b0);
        // Single 4-flit packet from port 0 (data 0x10..0x13), then quiet.
        run(4, 100, 0, 0, 100, 1'b1);
        run(3, 0, 0, 0, 100, 1'b1);
        // Owner bubble: port 0 starts, goes silent 5 cycles while port 1 waits.
        run(2, 0, 0, 0, 100, 1'b0);
        run(1, 100, 0, 0, 100, 1'b1);
        run(5, 0, 100, 0, 100, 1'b1);
        run(12, 100, 100, 100, 100, 1'b1);
        // All ports streaming 2-flit packets: interleave 0,1,2,0,1,2.
        run(1, 0, 0, 0, 100, 1'b0);
        set_len(2, 2);
        run(12, 100, 100, 100, 100, 1'b1);
        // Backpressure mid-packet for 4 cycles.
        run(3, 100, 100, 100, 100, 1'b1);
        run(4, 100, 100, 100, 0, 1'b1);
        run(6, 100, 100, 100, 100, 1'b1);
        // Reset after flit 2 of a 4-flit packet, then all ports request.
        run(1, 0, 0, 0, 100, 1'b0);
        set_len(4, 4);
        run(2, 100, 0, 0, 100, 1'b1);
        run(1, 100, 100, 100, 100, 1'b0);
        run(8, 100, 100, 100, 100, 1'b1);
        // Randomized traffic with random lengths, backpressure and occasional resets.
        set_len(1, 4);
        for (int r = 0; r < 8; r++) begin
            run(150, int'($urandom_range(100, 10)), int'($urandom_range(100, 10)),
                int'($urandom_range(100, 10)), int'($urandom_range(100, 30)), 1'b1);
            if (r % 3 == 2) run(1, 50, 50, 50, 50, 1'b0);
        end
        run(300, 95, 95, 95, 100, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
